cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter CYC_W, default 16, width of the executed-cycle counter.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  reset, asynchronous and active-high.
REQ-004 CMD_VALID  input  1  command request.
REQ-005 CMD_READY  output  1  command accepted when CMD_VALID & CMD_READY on a rising edge.
REQ-006 CMD  input  2  opcode: 00 RUN, 01 STEP, 10 STOP, 11 SET_BP.
REQ-007 CMD_DATA  input  8  breakpoint address for SET_BP; ignored otherwise.
REQ-008 PC  input  8  current CPU program counter.
REQ-009 NextPC  input  8  CPU next-PC value.
REQ-010 CPU_CE  output  1  CPU clock enable; CPU commits NextPC only on edges where CPU_CE=1.
REQ-011 EN_L  output  1  active-low CPU enable, always equal to ~CPU_CE.
REQ-012 STATE  output  2  FSM state code.
REQ-013 HALTED  output  1  CPU has self-looped.
REQ-014 BP_HIT  output  1  sticky breakpoint-stop flag.
REQ-015 CYCLES  output  CYC_W  count of CPU_CE=1 cycles.

Function
REQ-016 FSM states SHALL be IDLE=00, RUN=01, STEP=10, HLT=11; STATE reflects the current state register.
REQ-017 CPU_CE SHALL be 1 exactly when state is RUN or STEP (Moore output, no combinational path from CMD).
REQ-018 CMD_READY SHALL be 1 in IDLE, RUN and HLT, and 0 in STEP.
REQ-019 IDLE: accepted RUN -> RUN, clears BP_HIT; accepted STEP -> STEP, clears BP_HIT; SET_BP loads BP_ADDR=CMD_DATA and sets BP_EN=1, stays IDLE; STOP clears BP_EN, stays IDLE.
REQ-020 Self-loop condition SL = CPU_CE & (NextPC == PC); breakpoint condition BC = CPU_CE & BP_EN & (NextPC == BP_ADDR).
REQ-021 RUN: evaluated each cycle with priority SL > BC > accepted STOP > stay; SL -> HLT and HALTED=1; BC -> IDLE and BP_HIT=1; STOP -> IDLE; RUN, STEP, SET_BP in RUN SHALL be accepted and ignored.
REQ-022 The CPU SHALL commit the cycle on which SL or BC is detected (CPU_CE was 1 that cycle); CPU_CE is 0 from the following cycle, so after BC the CPU PC equals BP_ADDR.
REQ-023 STEP: lasts exactly one cycle; next state HLT (HALTED=1) if SL, else IDLE; BP_HIT set if BC and not SL.
REQ-024 HLT: CPU_CE=0; accepted STOP -> IDLE and clears HALTED; all other commands accepted and ignored.
REQ-025 BP_ADDR, BP_EN, BP_HIT, HALTED SHALL hold value except on the events above.
REQ-026 CYCLES SHALL increment by 1 on every edge with CPU_CE=1, saturating at all-ones (no wrap); it is cleared only by RESET.
REQ-027 A command presented while CMD_READY=0 SHALL NOT be accepted and has no effect; the requester holds it until accepted.
REQ-028 Breakpoint at the PC where RUN starts does not stop before executing: only NextPC is compared.

Reset
REQ-029 RESET=1 SHALL immediately (asynchronously) force state IDLE, CPU_CE=0, EN_L=1, HALTED=0, BP_HIT=0, BP_EN=0, BP_ADDR=00h, CYCLES=0, CMD_READY=1.
REQ-030 RESET asserted mid-RUN or mid-STEP SHALL drop CPU_CE without waiting for a clock edge; first edge after RESET deasserts executes no CPU cycle.

Verification
REQ-031 Reset, then STEP with PC=00h, NextPC=02h -> CPU_CE=1 for exactly one cycle, STATE returns 00, CYCLES=1, HALTED=0.
REQ-032 SET_BP 08h, RUN, PC advancing 00h,02h,04h,06h (NextPC=PC+2) -> CPU_CE high 4 cycles, last with NextPC=08h, then STATE=00, BP_HIT=1, CYCLES=4.
REQ-033 RUN with PC=NextPC=10h on first run cycle -> STATE=11, HALTED=1, CPU_CE=0 next cycle; RUN ignored; STOP -> STATE=00, HALTED=0.
REQ-034 RUN, STOP issued same cycle as NextPC==PC -> HLT wins (HALTED=1); repeat with BP match and STOP same cycle -> IDLE with BP_HIT=1.
REQ-035 RUN, assert RESET between clock edges -> CPU_CE and STATE drop to 0 immediately, BP_EN=0, CYCLES=0.
REQ-036 Force CYC_W=4, run 20 cycles without stop -> CYCLES stays Fh from cycle 15 onward.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/breakpoint controller gating a CPU clock enable
// Registered Moore outputs; CPU_CE and CMD_READY are computed from the next state.
module cpu_run_ctrl #(
  parameter int CYC_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD,
  input  logic [7:0]       CMD_DATA,
  input  logic [7:0]       PC,
  input  logic [7:0]       NextPC,
  output logic             CPU_CE,
  output logic             EN_L,
  output logic [1:0]       STATE,
  output logic             HALTED,
  output logic             BP_HIT,
  output logic [CYC_W-1:0] CYCLES
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HLT  = 2'b11
  } state_t;

  localparam logic [1:0] OP_RUN    = 2'b00;
  localparam logic [1:0] OP_STEP   = 2'b01;
  localparam logic [1:0] OP_STOP   = 2'b10;
  localparam logic [1:0] OP_SET_BP = 2'b11;
  localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

  state_t     state;
  state_t     nxt;
  logic       bp_en;
  logic [7:0] bp_addr;
  logic       accept;
  logic       sl;
  logic       bc;

  assign accept = CMD_VALID & CMD_READY;
  assign sl     = CPU_CE & (NextPC == PC);
  assign bc     = CPU_CE & bp_en & (NextPC == bp_addr);
  assign STATE  = state;
  assign EN_L   = ~CPU_CE;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && CMD == OP_RUN)       nxt = S_RUN;
        else if (accept && CMD == OP_STEP) nxt = S_STEP;
      end
      S_RUN: begin
        if (sl)                            nxt = S_HLT;
        else if (bc)                       nxt = S_IDLE;
        else if (accept && CMD == OP_STOP) nxt = S_IDLE;
      end
      S_STEP:  nxt = sl ? S_HLT : S_IDLE;
      S_HLT:   if (accept && CMD == OP_STOP) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      CPU_CE    <= 1'b0;
      CMD_READY <= 1'b1;
      HALTED    <= 1'b0;
      BP_HIT    <= 1'b0;
      bp_en     <= 1'b0;
      bp_addr   <= 8'h00;
      CYCLES    <= '0;
    end else begin
      state     <= nxt;
      CPU_CE    <= (nxt == S_RUN) || (nxt == S_STEP);
      CMD_READY <= (nxt != S_STEP);

      if (CPU_CE && CYCLES != '1) CYCLES <= CYCLES + CYC_ONE;

      if (state == S_IDLE && accept) begin
        case (CMD)
          OP_SET_BP: begin
            bp_addr <= CMD_DATA;
            bp_en   <= 1'b1;
          end
          OP_STOP: bp_en  <= 1'b0;
          default: BP_HIT <= 1'b0;
        endcase
      end

      // A self-loop outranks a breakpoint hit on the same cycle
      if (bc && !sl) BP_HIT <= 1'b1;
      if (sl) HALTED <= 1'b1;
      else if (state == S_HLT && accept && CMD == OP_STOP) HALTED <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  typedef struct packed {
    logic [1:0]  st;
    logic        ce;
    logic        en_l;
    logic        halted;
    logic        bp_hit;
    logic        rdy;
    logic [15:0] cyc;
  } snap_t;

  typedef struct packed {
    logic       v;
    logic [1:0] cmd;
    logic [7:0] data;
    logic [7:0] pc;
    logic [7:0] npc;
  } stim_t;

  localparam logic [1:0] RUN = 2'b00, STEP = 2'b01, STOP = 2'b10, SETBP = 2'b11;

  logic        CLK, RESET, CMD_VALID, CMD_READY, CPU_CE, EN_L, HALTED, BP_HIT;
  logic [1:0]  CMD, STATE;
  logic [7:0]  CMD_DATA, PC, NextPC;
  logic [15:0] CYCLES;

  logic        RESET4, CMD_VALID4, CMD_READY4, CPU_CE4, EN_L4, HALTED4, BP_HIT4;
  logic [1:0]  CMD4, STATE4;
  logic [7:0]  CMD_DATA4, PC4, NextPC4;
  logic [3:0]  CYCLES4;

  int checks = 0;
  int errors = 0;
  snap_t exp_q[$];

  cpu_run_ctrl #(.CYC_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD(CMD), .CMD_DATA(CMD_DATA), .PC(PC), .NextPC(NextPC), .CPU_CE(CPU_CE),
    .EN_L(EN_L), .STATE(STATE), .HALTED(HALTED), .BP_HIT(BP_HIT), .CYCLES(CYCLES)
  );

  cpu_run_ctrl #(.CYC_W(4)) dut4 (
    .CLK(CLK), .RESET(RESET4), .CMD_VALID(CMD_VALID4), .CMD_READY(CMD_READY4),
    .CMD(CMD4), .CMD_DATA(CMD_DATA4), .PC(PC4), .NextPC(NextPC4), .CPU_CE(CPU_CE4),
    .EN_L(EN_L4), .STATE(STATE4), .HALTED(HALTED4), .BP_HIT(BP_HIT4), .CYCLES(CYCLES4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected outputs from the spec rules: CE in RUN/STEP, ready everywhere but STEP
  function automatic snap_t mk(input logic [1:0] st, input logic h, input logic b, input int c);
    snap_t s;
    s.st     = st;
    s.ce     = (st == 2'd1) || (st == 2'd2);
    s.en_l   = ~s.ce;
    s.halted = h;
    s.bp_hit = b;
    s.rdy    = (st != 2'd2);
    s.cyc    = c[15:0];
    return s;
  endfunction

  function automatic snap_t snap();
    snap_t s;
    s.st = STATE; s.ce = CPU_CE; s.en_l = EN_L; s.halted = HALTED;
    s.bp_hit = BP_HIT; s.rdy = CMD_READY; s.cyc = CYCLES;
    return s;
  endfunction

  function automatic stim_t sti(input logic v, input logic [1:0] c, input logic [7:0] d,
                                input logic [7:0] p, input logic [7:0] n);
    stim_t s;
    s.v = v; s.cmd = c; s.data = d; s.pc = p; s.npc = n;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    CMD_VALID = s.v; CMD = s.cmd; CMD_DATA = s.data; PC = s.pc; NextPC = s.npc;
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b1; CMD_VALID = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    snap_t got, want;
    RESET = 1'b1; CMD_VALID = 1'b0; CMD = RUN; CMD_DATA = 8'h00; PC = 8'h00; NextPC = 8'h00;
    exp_q.push_back(mk(2'd0, 1'b0, 1'b0, 0));
    #1;
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset got %h want %h", got, want);
    end
    @(posedge CLK); #1; RESET = 1'b0;
  endtask

  task automatic test_step();
    stim_t s[$]; snap_t e[$]; snap_t got, want;
    apply_reset();
    s.push_back(sti(1, STEP, 0, 8'h00, 8'h02)); e.push_back(mk(2, 0, 0, 0));
    s.push_back(sti(1, RUN,  0, 8'h00, 8'h02)); e.push_back(mk(0, 0, 0, 1));
    s.push_back(sti(1, RUN,  0, 8'h00, 8'h02)); e.push_back(mk(1, 0, 0, 1));
    s.push_back(sti(1, STOP, 0, 8'h02, 8'h04)); e.push_back(mk(0, 0, 0, 2));
    s.push_back(sti(0, RUN,  0, 8'h04, 8'h06)); e.push_back(mk(0, 0, 0, 2));
    for (int i = 0; i < s.size(); i++) begin
      exp_q.push_back(e[i]);
      drive(s[i]);
      got = snap(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL step[%0d] got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_bp_run();
    stim_t s[$]; snap_t e[$]; snap_t got, want;
    apply_reset();
    s.push_back(sti(1, SETBP, 8'h08, 8'h00, 8'h02)); e.push_back(mk(0, 0, 0, 0));
    s.push_back(sti(1, RUN,   0, 8'h00, 8'h02));     e.push_back(mk(1, 0, 0, 0));
    s.push_back(sti(0, RUN,   0, 8'h00, 8'h02));     e.push_back(mk(1, 0, 0, 1));
    s.push_back(sti(0, RUN,   0, 8'h02, 8'h04));     e.push_back(mk(1, 0, 0, 2));
    s.push_back(sti(1, SETBP, 8'h77, 8'h04, 8'h06)); e.push_back(mk(1, 0, 0, 3));
    s.push_back(sti(0, RUN,   0, 8'h06, 8'h08));     e.push_back(mk(0, 0, 1, 4));
    s.push_back(sti(0, RUN,   0, 8'h08, 8'h0A));     e.push_back(mk(0, 0, 1, 4));
    s.push_back(sti(1, RUN,   0, 8'h08, 8'h0A));     e.push_back(mk(1, 0, 0, 4));
    s.push_back(sti(0, RUN,   0, 8'h08, 8'h0A));     e.push_back(mk(1, 0, 0, 5));
    s.push_back(sti(1, STOP,  0, 8'h0A, 8'h0C));     e.push_back(mk(0, 0, 0, 6));
    for (int i = 0; i < s.size(); i++) begin
      exp_q.push_back(e[i]);
      drive(s[i]);
      got = snap(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL bp_run[%0d] got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_halt();
    stim_t s[$]; snap_t e[$]; snap_t got, want;
    apply_reset();
    s.push_back(sti(1, RUN,  0, 8'h10, 8'h10)); e.push_back(mk(1, 0, 0, 0));
    s.push_back(sti(0, RUN,  0, 8'h10, 8'h10)); e.push_back(mk(3, 1, 0, 1));
    s.push_back(sti(1, RUN,  0, 8'h10, 8'h10)); e.push_back(mk(3, 1, 0, 1));
    s.push_back(sti(1, STEP, 0, 8'h10, 8'h10)); e.push_back(mk(3, 1, 0, 1));
    s.push_back(sti(1, STOP, 0, 8'h10, 8'h10)); e.push_back(mk(0, 0, 0, 1));
    s.push_back(sti(0, RUN,  0, 8'h10, 8'h10)); e.push_back(mk(0, 0, 0, 1));
    for (int i = 0; i < s.size(); i++) begin
      exp_q.push_back(e[i]);
      drive(s[i]);
      got = snap(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL halt[%0d] got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_priority();
    stim_t s[$]; snap_t e[$]; snap_t got, want;
    apply_reset();
    s.push_back(sti(1, RUN,   0, 8'h00, 8'h02));     e.push_back(mk(1, 0, 0, 0));
    s.push_back(sti(1, STOP,  0, 8'h20, 8'h20));     e.push_back(mk(3, 1, 0, 1));
    s.push_back(sti(1, STOP,  0, 8'h20, 8'h20));     e.push_back(mk(0, 0, 0, 1));
    s.push_back(sti(1, SETBP, 8'h30, 8'h00, 8'h02)); e.push_back(mk(0, 0, 0, 1));
    s.push_back(sti(1, RUN,   0, 8'h00, 8'h02));     e.push_back(mk(1, 0, 0, 1));
    s.push_back(sti(1, STOP,  0, 8'h2E, 8'h30));     e.push_back(mk(0, 0, 1, 2));
    s.push_back(sti(1, STOP,  0, 8'h2E, 8'h30));     e.push_back(mk(0, 0, 1, 2));
    s.push_back(sti(1, RUN,   0, 8'h2E, 8'h30));     e.push_back(mk(1, 0, 0, 2));
    s.push_back(sti(0, RUN,   0, 8'h2E, 8'h30));     e.push_back(mk(1, 0, 0, 3));
    s.push_back(sti(1, STOP,  0, 8'h30, 8'h32));     e.push_back(mk(0, 0, 0, 4));
    s.push_back(sti(1, SETBP, 8'h40, 8'h3E, 8'h40)); e.push_back(mk(0, 0, 0, 4));
    s.push_back(sti(1, STEP,  0, 8'h3E, 8'h40));     e.push_back(mk(2, 0, 0, 4));
    s.push_back(sti(0, RUN,   0, 8'h3E, 8'h40));     e.push_back(mk(0, 0, 1, 5));
    s.push_back(sti(1, STEP,  0, 8'h50, 8'h50));     e.push_back(mk(2, 0, 0, 5));
    s.push_back(sti(0, RUN,   0, 8'h50, 8'h50));     e.push_back(mk(3, 1, 0, 6));
    s.push_back(sti(1, STOP,  0, 8'h50, 8'h50));     e.push_back(mk(0, 0, 0, 6));
    for (int i = 0; i < s.size(); i++) begin
      exp_q.push_back(e[i]);
      drive(s[i]);
      got = snap(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL priority[%0d] got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    stim_t s[$]; snap_t e[$]; snap_t got, want;
    apply_reset();
    s.push_back(sti(1, SETBP, 8'h55, 8'h00, 8'h02)); e.push_back(mk(0, 0, 0, 0));
    s.push_back(sti(1, RUN,   0, 8'h00, 8'h02));     e.push_back(mk(1, 0, 0, 0));
    s.push_back(sti(0, RUN,   0, 8'h02, 8'h04));     e.push_back(mk(1, 0, 0, 1));
    s.push_back(sti(0, RUN,   0, 8'h04, 8'h06));     e.push_back(mk(0, 0, 0, 0));
    s.push_back(sti(1, RUN,   0, 8'h54, 8'h55));     e.push_back(mk(1, 0, 0, 0));
    s.push_back(sti(0, RUN,   0, 8'h54, 8'h55));     e.push_back(mk(1, 0, 0, 1));
    s.push_back(sti(1, STOP,  0, 8'h55, 8'h57));     e.push_back(mk(0, 0, 0, 2));
    for (int i = 0; i < s.size(); i++) begin
      if (i == 3) begin
        #2 RESET = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0));
        #1;
        got = snap(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin
          errors++; $display("FAIL async_reset got %h want %h", got, want);
        end
        #1 RESET = 1'b0;
      end
      exp_q.push_back(e[i]);
      drive(s[i]);
      got = snap(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset_mid[%0d] got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] want, got;
    logic [7:0] exp4_q[$];
    RESET4 = 1'b1;
    @(posedge CLK); #1;
    RESET4 = 1'b0;
    CMD_VALID4 = 1'b1; CMD4 = RUN;
    exp4_q.push_back({2'b01, 1'b1, 1'b0, 4'd0});
    @(posedge CLK); #1;
    CMD_VALID4 = 1'b0;
    got = {STATE4, CPU_CE4, EN_L4, CYCLES4}; want = exp4_q.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL sat_start got %h want %h", got, want);
    end
    for (int k = 1; k <= 20; k++) begin
      exp4_q.push_back({2'b01, 1'b1, 1'b0, (k > 15) ? 4'hF : 4'(k)});
      @(posedge CLK); #1;
      got = {STATE4, CPU_CE4, EN_L4, CYCLES4}; want = exp4_q.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL sat[%0d] got %h want %h", k, got, want);
      end
    end
  endtask

  initial begin
    RESET4 = 1'b1; CMD_VALID4 = 1'b0; CMD4 = RUN; CMD_DATA4 = 8'h00;
    PC4 = 8'h00; NextPC4 = 8'h02;
    test_reset();
    test_step();
    test_bp_run();
    test_halt();
    test_priority();
    test_reset_mid_run();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
